// File: rtl/stack_pkg.sv
// Shared definitions for the glyph stack buffer: word geometry and packed entry layout.
package stack_pkg;

   localparam int ADDR_WIDTH    = 8;
   localparam int CHAR_ID_WIDTH = 8;
   localparam int X_WIDTH       = 9;
   localparam int Y_WIDTH       = 9;
   localparam int DATA_WIDTH    = CHAR_ID_WIDTH + X_WIDTH + Y_WIDTH;

   typedef struct packed {
      logic [CHAR_ID_WIDTH-1:0] char_id;
      logic [X_WIDTH-1:0]       x;
      logic [Y_WIDTH-1:0]       y;
   } stack_entry_t;

   function automatic stack_entry_t to_entry(input logic [DATA_WIDTH-1:0] word);
      return stack_entry_t'(word);
   endfunction

endpackage

// File: rtl/stack_mem.sv
// Storage for the glyph stack: one synchronous write port, one asynchronous read port.
// Define STACK_MEM_BYPASS_EN to forward same-cycle write data onto a matching read.
module stack_mem
   import stack_pkg::*;
#(
   parameter int ADDR_WIDTH = stack_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = stack_pkg::DATA_WIDTH
) (
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic [ADDR_WIDTH-1:0] out_address,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0] in_address,
   input  logic                  we,
   input  logic                  clock,
   input  logic                  reset
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[in_address] = in_data;
      end
   end

   // Reset clears every entry at once, so an in-flight write never lands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      out_data = mem_q[out_address];
`ifdef STACK_MEM_BYPASS_EN
      if (we && !reset && (in_address == out_address)) begin
         out_data = in_data;
      end
`endif
   end

endmodule

// File: tb/tb_stack_mem.sv
// Randomised self-checking bench for stack_mem against an array reference model.
module tb_stack_mem;

   localparam int AW    = 8;
   localparam int DW    = 26;
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] out_data;
   logic [AW-1:0] out_address;
   logic [DW-1:0] in_data;
   logic [AW-1:0] in_address;
   logic          we;
   logic          clock;
   logic          reset;

   int compared;
   int mismatched;

   logic [DW-1:0] model [DEPTH];

   stack_mem dut (
      .out_data    (out_data),
      .out_address (out_address),
      .in_data     (in_data),
      .in_address  (in_address),
      .we          (we),
      .clock       (clock),
      .reset       (reset)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DW-1:0] expected_out();
      if (reset) return '0;
`ifdef STACK_MEM_BYPASS_EN
      if (we && in_address == out_address) return in_data;
`endif
      return model[out_address];
   endfunction

   // Model commits what the edge should capture, then the edge passes.
   task automatic tick();
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end else if (we) begin
         model[in_address] = in_data;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [AW-1:0] addrs [3];
      addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'd255;
      we = 1'b0; in_data = '0; in_address = '0; out_address = '0;
      reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         out_address = addrs[i];
         #1;
         compared++;
         if (out_data !== 26'h0) begin
            mismatched++;
            $display("FAIL reset_read addr=%0d got=%h want=%h", addrs[i], out_data, 26'h0);
         end
      end
   endtask

   task automatic test_write_read();
      we = 1'b1; in_address = 8'd5; in_data = 26'h1234567; out_address = 8'd5;
      tick();
      we = 1'b0;
      #1;
      compared++;
      if (out_data !== 26'h1234567) begin
         mismatched++;
         $display("FAIL write_read addr5 got=%h want=%h", out_data, 26'h1234567);
      end
      out_address = 8'd6;
      #1;
      compared++;
      if (out_data !== 26'h0) begin
         mismatched++;
         $display("FAIL write_read addr6 got=%h want=%h", out_data, 26'h0);
      end
   endtask

   task automatic test_simul_rw();
      we = 1'b1; in_address = 8'd2; in_data = 26'h0000BBB;
      tick();
      in_address = 8'd3; in_data = 26'h0000AAA; out_address = 8'd2;
      #1;
      compared++;
      if (out_data !== 26'h0000BBB) begin
         mismatched++;
         $display("FAIL simul_rw read2 got=%h want=%h", out_data, 26'h0000BBB);
      end
      tick();
      we = 1'b0; out_address = 8'd3;
      #1;
      compared++;
      if (out_data !== 26'h0000AAA) begin
         mismatched++;
         $display("FAIL simul_rw read3 got=%h want=%h", out_data, 26'h0000AAA);
      end
   endtask

   task automatic test_same_addr();
      logic [DW-1:0] want_before;
`ifdef STACK_MEM_BYPASS_EN
      want_before = 26'h2;
`else
      want_before = 26'h1;
`endif
      we = 1'b1; in_address = 8'd7; in_data = 26'h1;
      tick();
      in_data = 26'h2; out_address = 8'd7;
      #1;
      compared++;
      if (out_data !== want_before) begin
         mismatched++;
         $display("FAIL same_addr before_edge got=%h want=%h", out_data, want_before);
      end
      tick();
      we = 1'b0;
      #1;
      compared++;
      if (out_data !== 26'h2) begin
         mismatched++;
         $display("FAIL same_addr after_edge got=%h want=%h", out_data, 26'h2);
      end
   endtask

   task automatic test_reset_fill();
      int bad;
      we = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         in_address = AW'(a); in_data = DW'(a);
         tick();
      end
      we = 1'b0;
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         out_address = AW'(a);
         #0.1;
         if (out_data !== DW'(a)) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL fill_readback wrong_entries=%0d want=0", bad);
      end
      // Assert reset between edges with a write pending to address 9.
      @(negedge clock);
      out_address = 8'd200;
      we = 1'b1; in_address = 8'd9; in_data = 26'h3ABCDEF;
      reset = 1'b1;
      #1;
      compared++;
      if (out_data !== 26'h0) begin
         mismatched++;
         $display("FAIL reset_immediate addr200 got=%h want=%h", out_data, 26'h0);
      end
      out_address = 8'd9;
      #1;
      compared++;
      if (out_data !== 26'h0) begin
         mismatched++;
         $display("FAIL reset_bypass addr9 got=%h want=%h", out_data, 26'h0);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      @(posedge clock);
      #1;
      we = 1'b0;
      reset = 1'b0;
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         out_address = AW'(a);
         #0.1;
         if (out_data !== 26'h0) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL reset_clears_all nonzero_entries=%0d want=0", bad);
      end
   endtask

   task automatic test_we_low();
      int bad;
      we = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_address = AW'($urandom_range(0, DEPTH - 1));
         in_data = DW'($urandom);
         tick();
      end
      we = 1'b0; in_data = 26'h3FFFFFF;
      for (int i = 0; i < 10; i++) begin
         in_address = AW'($urandom_range(0, DEPTH - 1));
         tick();
      end
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         out_address = AW'(a);
         #0.1;
         if (out_data !== model[a]) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL we_low_hold changed_entries=%0d want=0", bad);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] want;
      for (int i = 0; i < 400; i++) begin
         we = ($urandom_range(0, 3) != 0);
         in_address = AW'($urandom_range(0, 15));
         in_data = DW'($urandom);
         out_address = ($urandom_range(0, 3) == 0) ? in_address : AW'($urandom_range(0, 15));
         #1;
         want = expected_out();
         compared++;
         if (out_data !== want) begin
            mismatched++;
            $display("FAIL random cyc=%0d we=%0b wa=%0d ra=%0d got=%h want=%h",
                     i, we, in_address, out_address, out_data, want);
         end
         tick();
      end
      we = 1'b0;
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b1;
      we = 1'b0;
      in_data = '0;
      in_address = '0;
      out_address = '0;
      test_reset();
      test_write_read();
      test_simul_rw();
      test_same_addr();
      test_reset_fill();
      test_we_low();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/stack_mem.md
STACK_MEM -- requirements
Module: stack_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, address width; depth = 2^ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 26, word width; holds {char_id[7:0], x[8:0], y[8:0]}.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 out_data  output  DATA_WIDTH  read data for out_address.
REQ-006 out_address  input  ADDR_WIDTH  read address.
REQ-007 in_data  input  DATA_WIDTH  write data.
REQ-008 in_address  input  ADDR_WIDTH  write address.
REQ-009 we  input  1  write enable, active-high.
REQ-010 Port order SHALL be out_data, out_address, in_data, in_address, we, clock, reset, so existing positional instantiations stay valid with reset appended.

Function
REQ-011 Memory SHALL be an array of 2^ADDR_WIDTH words of DATA_WIDTH bits.
REQ-012 On a rising clock edge with we=1 and reset=0, mem[in_address] SHALL take in_data; with we=0 the array SHALL be unchanged.
REQ-013 Read SHALL be asynchronous: out_data = mem[out_address] combinationally, zero-cycle latency, no read enable.
REQ-014 A write becomes visible on out_data in the cycle after its clock edge, not before, unless REQ-021 applies.
REQ-015 Without REQ-021, reading the address being written in the same cycle SHALL return the old contents until the edge.
REQ-016 Every address 0..2^ADDR_WIDTH-1 SHALL be valid; no out-of-range case exists and no wrap logic is needed.
REQ-017 Simultaneous read and write of different addresses SHALL both work in the same cycle.
REQ-018 Addresses and data SHALL be used unsigned; no arithmetic is performed inside the block.

Reset
REQ-019 While reset=1, all entries SHALL be cleared to zero immediately, without waiting for a clock edge, and writes SHALL be ignored.
REQ-020 During and after reset, out_data SHALL read 0 for every address until written; reset asserted mid-write SHALL win over the write.

Configuration
REQ-021 When macro STACK_MEM_BYPASS_EN is defined, we=1 with in_address==out_address SHALL drive out_data=in_data combinationally in that same cycle. Without the macro, REQ-015 holds.

Structure
REQ-022 Shared package stack_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH and the char_id/x/y field widths (8/9/9) plus a packed entry typedef; the enclosing stack buffer SHALL use the same package.
REQ-023 Single module; no sub-module; the bypass SHALL be a mux on the read path.

Verification
REQ-024 Assert reset, release, read addresses 0, 1 and 255 -> out_data=0 for all.
REQ-025 Write 26'h1234567 to addr 5, next cycle read addr 5 -> 26'h1234567; read addr 6 -> 0.
REQ-026 In one cycle write 26'h0000AAA to addr 3 and read addr 2, which holds 26'h0000BBB -> out_data=26'h0000BBB; next cycle read addr 3 -> 26'h0000AAA.
REQ-027 Addr 7 holds 26'h1; write 26'h2 to addr 7 while reading addr 7 -> out_data=26'h1 before the edge without STACK_MEM_BYPASS_EN, 26'h2 with it; 26'h2 after the edge in both builds.
REQ-028 Fill addrs 0..255 with value = addr, then assert reset between clock edges -> every address reads 0 immediately.
REQ-029 Hold we=0 with in_data=26'h3FFFFFF for 10 cycles -> no address changes.
